// File: rtl/dtree_seq_engine.sv
// dtree_seq_engine: programmable sequential decision-tree classifier.
// One shared comparator walks a register-held node table, one node per clock.
//
// Node entry layout (MSB..LSB): {is_leaf, feat_sel[2:0], shift[2:0], thr[7:0], left, right}
//   internal: (feat[feat_sel] >> shift) <= thr ? left : right
//   leaf    : class = thr[CLASS_W-1:0]
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   cfg_we/cfg_addr/cfg_wdata  node table write port, taken only while idle
//   cfg_ready                  write accepted this cycle (engine idle)
//   in_valid/in_ready/in_feat  sample handshake; feature i at [i*FEAT_W +: FEAT_W]
//   out_valid/out_ready        result handshake
//   out_class/out_err          result class, error flag (timeout or bad feature select)
//   busy                       engine not idle
module dtree_seq_engine #(
  parameter int unsigned N_FEAT    = 6,
  parameter int unsigned FEAT_W    = 8,
  parameter int unsigned CLASS_W   = 2,
  parameter int unsigned NODE_AW   = 6,
  parameter int unsigned MAX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [NODE_AW-1:0]          cfg_addr,
  input  logic [15+2*NODE_AW-1:0]     cfg_wdata,
  output logic                        cfg_ready,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_FEAT*FEAT_W-1:0]    in_feat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CLASS_W-1:0]          out_class,
  output logic                        out_err,
  output logic                        busy
);

  localparam int unsigned ENTRY_W = 15 + 2 * NODE_AW;
  localparam int unsigned N_NODES = 2 ** NODE_AW;
  localparam int unsigned DEPTH_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [ENTRY_W-1:0] LEAF_CLASS0 = {1'b1, {(ENTRY_W - 1){1'b0}}};
  localparam logic [DEPTH_W-1:0] LAST_DEPTH  = DEPTH_W'(MAX_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  state_e                      r_state;
  logic [ENTRY_W-1:0]          r_table [N_NODES];
  logic [N_FEAT*FEAT_W-1:0]    r_feat;
  logic [NODE_AW-1:0]          r_node_ptr;
  logic [DEPTH_W-1:0]          r_depth;
  logic                        r_out_valid;
  logic [CLASS_W-1:0]          r_out_class;
  logic                        r_out_err;

  logic [ENTRY_W-1:0]          w_entry;
  logic                        w_is_leaf;
  logic [2:0]                  w_feat_sel;
  logic [2:0]                  w_shift;
  logic [7:0]                  w_thr;
  logic [NODE_AW-1:0]          w_left;
  logic [NODE_AW-1:0]          w_right;
  logic [FEAT_W-1:0]           w_feat_val;
  logic                        w_feat_bad;
  logic                        w_go_left;
  logic                        w_idle;

  assign w_idle     = (r_state == StIdle);
  assign cfg_ready  = w_idle;
  // Config wins over a simultaneous sample; the sample waits a cycle.
  assign in_ready   = w_idle && !cfg_we;
  assign busy       = !w_idle;
  assign out_valid  = r_out_valid;
  assign out_class  = r_out_class;
  assign out_err    = r_out_err;

  assign w_entry    = r_table[r_node_ptr];
  assign w_is_leaf  = w_entry[ENTRY_W-1];
  assign w_feat_sel = w_entry[ENTRY_W-2 -: 3];
  assign w_shift    = w_entry[ENTRY_W-5 -: 3];
  assign w_thr      = w_entry[ENTRY_W-8 -: 8];
  assign w_left     = w_entry[2*NODE_AW-1 -: NODE_AW];
  assign w_right    = w_entry[NODE_AW-1:0];
  assign w_feat_bad = ({29'd0, w_feat_sel} >= N_FEAT);

  // Loop-based mux keeps out-of-range selects from indexing past the vector.
  always_comb begin
    w_feat_val = '0;
    for (int i = 0; i < int'(N_FEAT); i++) begin
      if (w_feat_sel == 3'(i)) w_feat_val = r_feat[i*FEAT_W +: FEAT_W];
    end
  end

  // Both sides zero-extended so the compare is unsigned regardless of FEAT_W.
  assign w_go_left = (32'(w_feat_val >> w_shift) <= 32'(w_thr));

  // Node table: reset restores every entry to leaf class 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_NODES); i++) r_table[i] <= LEAF_CLASS0;
    end else if (w_idle && cfg_we) begin
      r_table[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_feat      <= '0;
      r_node_ptr  <= '0;
      r_depth     <= '0;
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid && !cfg_we) begin
            r_feat     <= in_feat;
            r_node_ptr <= '0;
            r_depth    <= '0;
            r_state    <= StEval;
          end
        end
        StEval: begin
          if (w_is_leaf) begin
            r_out_class <= w_thr[CLASS_W-1:0];
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else if (w_feat_bad || (r_depth == LAST_DEPTH)) begin
            r_out_class <= '0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_node_ptr <= w_go_left ? w_left : w_right;
            r_depth    <= r_depth + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Scoreboard bench for dtree_seq_engine: the driver pushes expected results,
// a negedge monitor pops and compares class, error flag and latency.
module tb_dtree_seq_engine;

  localparam int N_FEAT  = 6;
  localparam int FEAT_W  = 8;
  localparam int CLASS_W = 2;
  localparam int NODE_AW = 6;
  localparam int ENTRY_W = 15 + 2 * NODE_AW;

  logic                     clk;
  logic                     rst;
  logic                     cfg_we;
  logic [NODE_AW-1:0]       cfg_addr;
  logic [ENTRY_W-1:0]       cfg_wdata;
  logic                     cfg_ready;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic                     out_err;
  logic                     busy;

  dtree_seq_engine #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W), .NODE_AW(NODE_AW), .MAX_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CLASS_W-1:0] cls;
    logic               err;
    int                 lat;
    int                 acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on each rising out_valid.
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got class %0d err %0d expected no result",
                 out_class, out_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_class", 32'(out_class), 32'(e.cls));
        chk("out_err", 32'(out_err), 32'(e.err));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    prev_valid = out_valid;
  end

  function automatic logic [ENTRY_W-1:0] node(input logic leaf, input logic [2:0] fs,
                                              input logic [2:0] sh, input logic [7:0] thr,
                                              input logic [5:0] l, input logic [5:0] r);
    return {leaf, fs, sh, thr, l, r};
  endfunction

  function automatic logic [N_FEAT*FEAT_W-1:0] feats(input logic [7:0] x5, input logic [7:0] x3);
    logic [N_FEAT*FEAT_W-1:0] f;
    f = '0;
    f[5*FEAT_W +: FEAT_W] = x5;
    f[3*FEAT_W +: FEAT_W] = x3;
    return f;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy %0d expected 0", busy);
    end
  endtask

  task automatic cfg(input logic [NODE_AW-1:0] a, input logic [ENTRY_W-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [N_FEAT*FEAT_W-1:0] f, input logic [CLASS_W-1:0] cls,
                      input logic err, input int lat);
    int n;
    exp_t e;
    @(negedge clk);
    in_feat = f;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready %0d expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.cls = cls; e.err = err; e.lat = lat; e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_feat = '1;  // engine must ignore in_feat after accept
  endtask

  initial begin
    int n;
    exp_t e;
    rst = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_feat = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("reset_out_class", 32'(out_class), 32'd0);
    send(feats(8'd77, 8'd200), 2'd0, 1'b0, 1);
    wait_idle();

    // Three-level tree
    cfg(6'd0, node(1'b0, 3'd5, 3'd2, 8'd3, 6'd1, 6'd2));
    cfg(6'd1, node(1'b1, 3'd0, 3'd0, 8'd1, 6'd0, 6'd0));
    cfg(6'd2, node(1'b0, 3'd3, 3'd5, 8'd2, 6'd3, 6'd4));
    cfg(6'd3, node(1'b1, 3'd0, 3'd0, 8'd2, 6'd0, 6'd0));
    cfg(6'd4, node(1'b1, 3'd0, 3'd0, 8'd3, 6'd0, 6'd0));
    send(feats(8'd12, 8'd0), 2'd1, 1'b0, 2);
    send(feats(8'd16, 8'd64), 2'd2, 1'b0, 3);
    send(feats(8'd255, 8'd96), 2'd3, 1'b0, 3);
    wait_idle();

    // Bad feature select, then timeout on a self-loop
    cfg(6'd0, node(1'b0, 3'd7, 3'd0, 8'd0, 6'd0, 6'd0));
    send(feats(8'd1, 8'd1), 2'd0, 1'b1, 1);
    wait_idle();
    cfg(6'd0, node(1'b0, 3'd0, 3'd0, 8'd255, 6'd0, 6'd0));
    send(feats(8'd1, 8'd1), 2'd0, 1'b1, 16);
    wait_idle();

    // Backpressure: result held stable, config dropped while not idle
    cfg(6'd0, node(1'b0, 3'd5, 3'd2, 8'd3, 6'd1, 6'd2));
    out_ready = 1'b0;
    send(feats(8'd12, 8'd0), 2'd1, 1'b0, 2);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = node(1'b1, 3'd0, 3'd0, 8'd3, 6'd0, 6'd0);
      end else begin
        cfg_we = 1'b0;
      end
      #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_class", 32'(out_class), 32'd1);
      chk("hold_out_err", 32'(out_err), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_cfg_ready", 32'(cfg_ready), 32'd0);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    send(feats(8'd12, 8'd0), 2'd1, 1'b0, 2);
    wait_idle();

    // Config and sample in the same idle cycle: write lands first
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = node(1'b1, 3'd0, 3'd0, 8'd2, 6'd0, 6'd0);
    in_valid = 1'b1; in_feat = feats(8'd12, 8'd0);
    #1;
    chk("collide_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    chk("collide_in_ready_next", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    e.cls = 2'd2; e.err = 1'b0; e.lat = 2; e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();

    // Asynchronous reset mid-evaluation
    cfg(6'd0, node(1'b0, 3'd0, 3'd0, 8'd255, 6'd0, 6'd0));
    @(negedge clk);
    in_valid = 1'b1; in_feat = '0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_stale_busy", 32'(busy), 32'd0);
    send(feats(8'd12, 8'd0), 2'd0, 1'b0, 1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
